instruction_queue: RTL and testbench



---
 rtl/instruction_queue.sv | 185 ++++++++++++++++++
 tb/tb_instruction_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_queue.sv
// Byte-serial instruction assembler feeding a DEPTH-entry FIFO for the GPU command decoder.
// Optional build macro ARG_COUNT_EN adds per-entry argument counts and a sticky overrun flag.
module instruction_queue #(
  parameter int INSTR_BYTES = 4,
  parameter int DEPTH       = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_we,
  input  logic                        i_en,
  input  logic [7:0]                  i_data,
  output logic                        o_ack,
  output logic [8*INSTR_BYTES-1:0]    o_instruction,
  output logic                        o_valid,
  input  logic                        i_pop,
  output logic [$clog2(DEPTH):0]      o_count
`ifdef ARG_COUNT_EN
  ,
  output logic [$clog2(INSTR_BYTES)-1:0] o_arg_count,
  output logic                           o_overrun
`endif
);

  localparam int IW = 8 * INSTR_BYTES;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(INSTR_BYTES) + 1;
  localparam int AW = $clog2(INSTR_BYTES);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [BW-1:0] BYTES_C = BW'(INSTR_BYTES);

  typedef enum logic [1:0] {IDLE, OPCODE, ARGS, COMMIT} state_t;

  state_t          state, state_nxt;
  logic            we_q, en_q;
  logic [7:0]      data_q;
  logic            ack_q;
  logic [BW-1:0]   byte_cnt;
  logic [IW-1:0]   asm_q, asm_shift;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;
  logic [IW-1:0]   mem [DEPTH];

  logic            byte_take, byte_done;
  logic            arg_store, arg_over;
  logic            push, pop;

  assign byte_take = (state == OPCODE || state == ARGS) && !en_q && !ack_q;
  assign byte_done = (state == OPCODE || state == ARGS) && en_q && ack_q;

  // Input registration stage
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      we_q <= 1'b1;
      en_q <= 1'b1;
    end else begin
      we_q <= i_we;
      en_q <= i_en;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_en) data_q <= i_data;
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (!we_q && count_q < DEPTH_C) state_nxt = OPCODE;
      OPCODE: begin
        if (byte_done)                         state_nxt = ARGS;
        else if (!byte_take && we_q && byte_cnt == '0) state_nxt = IDLE;
      end
      ARGS:   if (!byte_take && !byte_done && we_q) state_nxt = COMMIT;
      COMMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output decode and FIFO head presentation
  always_comb begin
    arg_store = 1'b0;
    arg_over  = 1'b0;
    push      = 1'b0;
    asm_shift = asm_q;
    if (state == ARGS && byte_take) begin
      if (byte_cnt < BYTES_C) arg_store = 1'b1;
      else                    arg_over  = 1'b1;
    end
    if (state == COMMIT) push = 1'b1;
    // Arguments enter at byte 1 and older arguments move up one byte
    for (int i = INSTR_BYTES - 1; i >= 2; i--) asm_shift[8*i +: 8] = asm_q[8*(i-1) +: 8];
    asm_shift[15:8] = data_q;
  end

  assign o_valid       = (count_q != '0);
  assign pop           = i_pop && o_valid;
  assign o_instruction = o_valid ? mem[rd_ptr] : '0;
  assign o_count       = count_q;
  assign o_ack         = ack_q;

  // Handshake and byte counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ack_q    <= 1'b0;
      byte_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          ack_q    <= 1'b0;
          byte_cnt <= '0;
        end
        OPCODE: begin
          if (byte_take) begin
            ack_q    <= 1'b1;
            byte_cnt <= BW'(1);
          end else if (byte_done) begin
            ack_q    <= 1'b0;
          end
        end
        ARGS: begin
          if (byte_take) begin
            ack_q <= 1'b1;
            if (arg_store) byte_cnt <= byte_cnt + BW'(1);
          end else if (byte_done) begin
            ack_q <= 1'b0;
          end
        end
        default: ack_q <= 1'b0;
      endcase
    end
  end

  // Assembly register; cleared in IDLE, so reset only needs to return the FSM there
  always_ff @(posedge i_clk) begin
    if (state == IDLE)            asm_q       <= '0;
    else if (state == OPCODE && byte_take) asm_q[7:0] <= data_q;
    else if (arg_store)           asm_q       <= asm_shift;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_reset) mem[wr_ptr] <= asm_q;
  end

`ifdef ARG_COUNT_EN
  logic [AW-1:0] argc_mem [DEPTH];
  logic          overrun_q;

  always_ff @(posedge i_clk) begin
    if (push && !i_reset) argc_mem[wr_ptr] <= AW'(byte_cnt - BW'(1));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)       overrun_q <= 1'b0;
    else if (arg_over) overrun_q <= 1'b1;
  end

  assign o_arg_count = o_valid ? argc_mem[rd_ptr] : '0;
  assign o_overrun   = overrun_q;
`endif

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: framing, FIFO ordering, full stall, overrun and reset.
module tb_instruction_queue;

  logic        i_clk = 1'b0;
  logic        i_reset, i_we, i_en, i_pop;
  logic [7:0]  i_data;
  logic        o_ack, o_valid;
  logic [31:0] o_instruction;
  logic [2:0]  o_count;
`ifdef ARG_COUNT_EN
  logic [1:0]  o_arg_count;
  logic        o_overrun;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  instruction_queue #(.INSTR_BYTES(4), .DEPTH(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_we(i_we), .i_en(i_en), .i_data(i_data),
    .o_ack(o_ack), .o_instruction(o_instruction), .o_valid(o_valid),
    .i_pop(i_pop), .o_count(o_count)
`ifdef ARG_COUNT_EN
    , .o_arg_count(o_arg_count), .o_overrun(o_overrun)
`endif
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input string tag, input int max);
    int k = 0;
    do begin tick(); k++; end while (o_ack !== lvl && k < max);
    chk(tag, {31'd0, o_ack}, {31'd0, lvl});
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    i_en = 1'b0;
    i_data = b;
    k = 0;
    do begin tick(); k++; end while (o_ack !== 1'b1 && k < 10);
    chk("ack_rise_latency", k, 2);
    i_en = 1'b1;
    k = 0;
    do begin tick(); k++; end while (o_ack !== 1'b0 && k < 10);
    chk("ack_fall_latency", k, 2);
  endtask

  task automatic send_frame(input logic [47:0] bytes, input int n, input bit pop_at_push,
                            input bit chk_pre);
    i_we = 1'b0;
    tick();
    tick();
    for (int i = 0; i < n; i++) send_byte(bytes[8*i +: 8]);
    i_we = 1'b1;
    tick();
    tick();
    if (chk_pre) chk("valid_before_commit", {31'd0, o_valid}, 32'd0);
    if (pop_at_push) i_pop = 1'b1;
    tick();
    i_pop = 1'b0;
  endtask

  task automatic pop_chk(input logic [31:0] exp, input string tag);
    chk(tag, o_instruction, exp);
    i_pop = 1'b1;
    tick();
    i_pop = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1;
    i_we    = 1'b1;
    i_en    = 1'b1;
    i_pop   = 1'b0;
    i_data  = 8'h00;
    repeat (3) tick();
    i_reset = 1'b0;
    tick();
    chk("rst_ack", {31'd0, o_ack}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_count", {29'd0, o_count}, 32'd0);
    chk("rst_instr", o_instruction, 32'd0);
`ifdef ARG_COUNT_EN
    chk("rst_overrun", {31'd0, o_overrun}, 32'd0);
    chk("rst_argc", {30'd0, o_arg_count}, 32'd0);
`endif

    // Full four-byte frame
    send_frame(48'h0000_CCBB_AA12, 4, 1'b0, 1'b1);
    chk("full_valid", {31'd0, o_valid}, 32'd1);
    chk("full_instr", o_instruction, 32'hAABBCC12);
    chk("full_count", {29'd0, o_count}, 32'd1);
`ifdef ARG_COUNT_EN
    chk("full_argc", {30'd0, o_arg_count}, 32'd3);
`endif
    i_pop = 1'b1;
    tick();
    i_pop = 1'b0;
    chk("pop_valid", {31'd0, o_valid}, 32'd0);
    chk("pop_instr", o_instruction, 32'd0);
    chk("pop_count", {29'd0, o_count}, 32'd0);

    // Opcode-only frame
    send_frame(48'h05, 1, 1'b0, 1'b1);
    chk("opc_instr", o_instruction, 32'h00000005);
`ifdef ARG_COUNT_EN
    chk("opc_argc", {30'd0, o_arg_count}, 32'd0);
`endif
    pop_chk(32'h00000005, "opc_pop_head");

    // Empty frame and pop on empty queue
    i_we = 1'b0;
    repeat (4) tick();
    i_we = 1'b1;
    repeat (4) tick();
    chk("empty_frame_count", {29'd0, o_count}, 32'd0);
    chk("empty_frame_valid", {31'd0, o_valid}, 32'd0);
    i_pop = 1'b1;
    tick();
    i_pop = 1'b0;
    chk("pop_empty_count", {29'd0, o_count}, 32'd0);

    // Fill the queue, then a fifth frame must stall until a pop
    send_frame(48'h3121, 2, 1'b0, 1'b0);
    send_frame(48'h42_3222, 3, 1'b0, 1'b0);
    send_frame(48'h23, 1, 1'b0, 1'b0);
    send_frame(48'hC3B2_A124, 4, 1'b0, 1'b0);
    chk("fill_count", {29'd0, o_count}, 32'd4);
    i_we = 1'b0;
    i_en = 1'b0;
    i_data = 8'h55;
    repeat (6) tick();
    chk("stall_ack", {31'd0, o_ack}, 32'd0);
    chk("stall_count", {29'd0, o_count}, 32'd4);
    pop_chk(32'h00003121, "stall_pop_head");
    wait_ack(1'b1, "stall_release_ack", 10);
    i_en = 1'b1;
    wait_ack(1'b0, "stall_release_ack_low", 10);
    i_we = 1'b1;
    repeat (3) tick();
    chk("refill_count", {29'd0, o_count}, 32'd4);
    pop_chk(32'h00324222, "order_1");
    pop_chk(32'h00000023, "order_2");
    pop_chk(32'hA1B2C324, "order_3");
    pop_chk(32'h00000055, "order_4");
    chk("drain_count", {29'd0, o_count}, 32'd0);

    // Simultaneous push and pop across pointer wrap
    send_frame(48'h7161, 2, 1'b0, 1'b0);
    send_frame(48'h62, 1, 1'b0, 1'b0);
    chk("pp_pre_count", {29'd0, o_count}, 32'd2);
    chk("pp_head", o_instruction, 32'h00007161);
    send_frame(48'h83_7363, 3, 1'b1, 1'b0);
    chk("pp_count", {29'd0, o_count}, 32'd2);
    pop_chk(32'h00000062, "pp_order_1");
    pop_chk(32'h00738363, "pp_order_2");
    chk("pp_drain_count", {29'd0, o_count}, 32'd0);

    // Six-byte frame: bytes past the fourth are acked and dropped
    send_frame(48'h0605_0403_0201, 6, 1'b0, 1'b0);
    chk("over_instr", o_instruction, 32'h02030401);
`ifdef ARG_COUNT_EN
    chk("over_flag", {31'd0, o_overrun}, 32'd1);
    chk("over_argc", {30'd0, o_arg_count}, 32'd3);
`endif
    pop_chk(32'h02030401, "over_pop_head");

    // Reset in the middle of a frame with one entry queued
    send_frame(48'h77, 1, 1'b0, 1'b0);
    chk("pre_rst_count", {29'd0, o_count}, 32'd1);
    i_we = 1'b0;
    tick();
    tick();
    send_byte(8'h9A);
    i_en = 1'b0;
    i_data = 8'h11;
    wait_ack(1'b1, "mid_frame_ack", 10);
    i_reset = 1'b1;
    i_we = 1'b1;
    i_en = 1'b1;
    tick();
    chk("mid_rst_ack", {31'd0, o_ack}, 32'd0);
    chk("mid_rst_count", {29'd0, o_count}, 32'd0);
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_instr", o_instruction, 32'd0);
`ifdef ARG_COUNT_EN
    chk("mid_rst_overrun", {31'd0, o_overrun}, 32'd0);
`endif
    i_reset = 1'b0;
    tick();
    send_frame(48'h0000_3322_119A, 4, 1'b0, 1'b1);
    chk("post_rst_instr", o_instruction, 32'h1122339A);
    chk("post_rst_count", {29'd0, o_count}, 32'd1);
    pop_chk(32'h1122339A, "post_rst_pop_head");
    chk("final_valid", {31'd0, o_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
